// File: rtl/fip_pkg.sv
// Shared signed fixed-point helpers and vector types for the intersector datapath.
package fip_pkg;

  localparam int FIP_XW  = 64;
  localparam int FIP_W   = 32;
  localparam int FIP_FRA = 16;

  typedef logic signed [FIP_XW-1:0] fip_wide_t;
  typedef logic signed [FIP_W-1:0]  fip_word_t;
  typedef fip_word_t [0:2]          vec3_t;
  typedef vec3_t [0:1]              ray_t;

  // Width-parametrised constants; callers truncate to their own word width.
  function automatic fip_wide_t fip_one(input int frac);
    return fip_wide_t'(1) <<< frac;
  endfunction

  function automatic fip_wide_t fip_max(input int w);
    return (fip_wide_t'(1) <<< (w - 1)) - fip_wide_t'(1);
  endfunction

  function automatic fip_wide_t fip_min(input int w);
    return -(fip_wide_t'(1) <<< (w - 1));
  endfunction

  function automatic fip_wide_t fip_smax(input fip_wide_t a, input fip_wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic fip_wide_t fip_smin(input fip_wide_t a, input fip_wide_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic fip_wide_t fip_sat_add(input fip_wide_t a, input fip_wide_t b, input int w);
    return fip_smin(fip_smax(a + b, fip_min(w)), fip_max(w));
  endfunction

endpackage

// File: rtl/fip_det3.sv
// Combinational 3x3 fixed-point determinant of three column vectors.
module fip_det3 #(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16
) (
  input  logic        [0:2][WIDTH-1:0] col0_i,
  input  logic        [0:2][WIDTH-1:0] col1_i,
  input  logic        [0:2][WIDTH-1:0] col2_i,
  output logic signed      [WIDTH-1:0] det_o
);

  localparam int PW = 3 * WIDTH;

  // Rescale after every multiply so each triple product stays in fixed point.
  function automatic logic signed [PW-1:0] tp(input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b,
                                              input logic signed [WIDTH-1:0] c);
    logic signed [PW-1:0] ab;
    ab = (PW'(a) * PW'(b)) >>> FRA_BITS;
    return (ab * PW'(c)) >>> FRA_BITS;
  endfunction

  logic signed [WIDTH-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2;
  logic signed [PW-1:0]    full;

  assign x0 = col0_i[0];
  assign y0 = col0_i[1];
  assign z0 = col0_i[2];
  assign x1 = col1_i[0];
  assign y1 = col1_i[1];
  assign z1 = col1_i[2];
  assign x2 = col2_i[0];
  assign y2 = col2_i[1];
  assign z2 = col2_i[2];

  assign full = tp(x0, y1, z2) - tp(x0, z1, y2)
              - tp(y0, x1, z2) + tp(y0, z1, x2)
              + tp(z0, x1, y2) - tp(z0, y1, x2);

  assign det_o = full[WIDTH-1:0];

endmodule

// File: rtl/tri_intersect_closest.sv
// Pipelined Cramer's-rule ray/triangle intersector with per-ray closest-hit reduction.
module tri_intersect_closest
  import fip_pkg::*;
#(
  parameter int                      WIDTH    = 32,
  parameter int                      FRA_BITS = 16,
  parameter int                      TAG_W    = 16,
  parameter logic signed [WIDTH-1:0] MIN_T    = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [0:2][0:2][WIDTH-1:0]  i_tri,
  input  logic [0:1][0:2][WIDTH-1:0]  i_ray,
  input  logic [TAG_W-1:0]            i_tag,
  input  logic                        i_last,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_hit,
  output logic [WIDTH-1:0]            o_t,
  output logic [TAG_W-1:0]            o_tag
);

  typedef logic signed [WIDTH-1:0]   word_t;
  typedef logic signed [2*WIDTH-1:0] dword_t;
  typedef word_t [0:2]               vec_t;

  localparam word_t ONE     = word_t'(fip_one(FRA_BITS));
  localparam word_t MAX_POS = word_t'(fip_max(WIDTH));
  localparam word_t MIN_NEG = word_t'(fip_min(WIDTH));

  // Saturating signed fixed-point quotient; a zero divisor yields 0 and is masked later.
  function automatic word_t fip_div(input word_t n, input word_t d);
    dword_t q;
    q = '0;
    if (d != '0) q = (dword_t'(n) <<< FRA_BITS) / dword_t'(d);
    if (q > dword_t'(MAX_POS)) return MAX_POS;
    if (q < dword_t'(MIN_NEG)) return MIN_NEG;
    return word_t'(q);
  endfunction

  logic adv;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  vec_t t1_d, t2_d, ep_d, n_d;
  vec_t t1_q, t2_q, ep_q, n_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  logic s1_last_q, s2_last_q, s3_last_q;
  word_t den_d, da_d, db_d, dt_d;
  word_t den_q, da_q, db_q, dt_q;
  logic  s3_den_nz_q;
  word_t a_q, b_q, t_q;
  fip_wide_t sum_ab;
  logic hit, take;
  logic m_hit;
  word_t m_t;
  logic [TAG_W-1:0] m_tag;
  logic acc_hit_d, acc_hit_q, out_hit_d, out_hit_q, out_valid_q;
  word_t acc_t_d, acc_t_q, out_t_d, out_t_q;
  logic [TAG_W-1:0] acc_tag_d, acc_tag_q, out_tag_d, out_tag_q;

  assign adv     = !out_valid_q || i_ready;
  assign o_ready = adv;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      t1_d[k] = i_tri[1][k] - i_tri[0][k];
      t2_d[k] = i_tri[2][k] - i_tri[0][k];
      ep_d[k] = i_ray[0][k] - i_tri[0][k];
      n_d[k]  = -i_ray[1][k];
    end
  end

  fip_det3 #(.WIDTH(WIDTH), .FRA_BITS(FRA_BITS)) u_den (
    .col0_i(t1_q), .col1_i(t2_q), .col2_i(n_q),  .det_o(den_d));
  fip_det3 #(.WIDTH(WIDTH), .FRA_BITS(FRA_BITS)) u_da (
    .col0_i(ep_q), .col1_i(t2_q), .col2_i(n_q),  .det_o(da_d));
  fip_det3 #(.WIDTH(WIDTH), .FRA_BITS(FRA_BITS)) u_db (
    .col0_i(t1_q), .col1_i(ep_q), .col2_i(n_q),  .det_o(db_d));
  fip_det3 #(.WIDTH(WIDTH), .FRA_BITS(FRA_BITS)) u_dt (
    .col0_i(t1_q), .col1_i(t2_q), .col2_i(ep_q), .det_o(dt_d));

  // NOTE: datapath registers carry no reset; the stage valids alone qualify them.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      ep_q        <= ep_d;
      n_q         <= n_d;
      s1_tag_q    <= i_tag;
      s1_last_q   <= i_last;
      den_q       <= den_d;
      da_q        <= da_d;
      db_q        <= db_d;
      dt_q        <= dt_d;
      s2_tag_q    <= s1_tag_q;
      s2_last_q   <= s1_last_q;
      s3_den_nz_q <= (den_q != '0);
      a_q         <= fip_div(da_q, den_q);
      b_q         <= fip_div(db_q, den_q);
      t_q         <= fip_div(dt_q, den_q);
      s3_tag_q    <= s2_tag_q;
      s3_last_q   <= s2_last_q;
    end
  end

  assign sum_ab = fip_sat_add(fip_wide_t'(a_q), fip_wide_t'(b_q), WIDTH);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    hit   = s3_valid_q && s3_den_nz_q && (a_q >= 0) && (b_q >= 0) &&
            (sum_ab <= fip_wide_t'(ONE)) && (t_q >= MIN_T);
    // Strict less-than keeps the earlier triangle on equal t.
    take  = hit && (!acc_hit_q || (t_q < acc_t_q));
    m_hit = acc_hit_q || take;
    m_t   = take ? t_q      : acc_t_q;
    m_tag = take ? s3_tag_q : acc_tag_q;

    acc_hit_d = acc_hit_q;
    acc_t_d   = acc_t_q;
    acc_tag_d = acc_tag_q;
    out_hit_d = out_hit_q;
    out_t_d   = out_t_q;
    out_tag_d = out_tag_q;
    if (s3_valid_q) begin
      if (s3_last_q) begin
        out_hit_d = m_hit;
        out_t_d   = m_t;
        out_tag_d = m_tag;
        acc_hit_d = 1'b0;
        acc_t_d   = MAX_POS;
        acc_tag_d = '0;
      end else begin
        acc_hit_d = m_hit;
        acc_t_d   = m_t;
        acc_tag_d = m_tag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      acc_hit_q   <= 1'b0;
      acc_t_q     <= MAX_POS;
      acc_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_t_q     <= MAX_POS;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q  <= i_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q && s3_last_q;
      acc_hit_q   <= acc_hit_d;
      acc_t_q     <= acc_t_d;
      acc_tag_q   <= acc_tag_d;
      out_hit_q   <= out_hit_d;
      out_t_q     <= out_t_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_hit   = out_hit_q;
  assign o_t     = out_t_q;
  assign o_tag   = out_tag_q;

endmodule

// File: tb/tb_tri_intersect_closest.sv
// Directed bench for tri_intersect_closest: hand-computed hits, misses, ties, stalls and reset.
module tb_tri_intersect_closest;

  localparam logic [31:0] Q1  = 32'h0001_0000;
  localparam logic [31:0] Q2  = 32'h0002_0000;
  localparam logic [31:0] Q3  = 32'h0003_0000;
  localparam logic [31:0] QH  = 32'h0000_8000;
  localparam logic [31:0] Q4  = 32'h0000_4000;
  localparam logic [31:0] Q34 = 32'h0000_C000;
  localparam logic [31:0] M1  = 32'hFFFF_0000;
  localparam logic [31:0] M2  = 32'hFFFE_0000;
  localparam logic [31:0] MH  = 32'hFFFF_8000;
  localparam logic [31:0] MAXP = 32'h7FFF_FFFF;

  typedef logic [0:2][0:2][31:0] tri_t;
  typedef logic [0:1][0:2][31:0] ray_bt;
  typedef struct packed {
    logic        hit;
    logic [31:0] t;
    logic [15:0] tag;
  } res_t;

  logic        clk = 1'b0;
  logic        i_rstn, i_valid, i_last, i_ready;
  logic        o_ready, o_valid, o_hit;
  tri_t        i_tri;
  ray_bt       i_ray;
  logic [15:0] i_tag, o_tag;
  logic [31:0] o_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  res_t res_q[$];

  tri_intersect_closest dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_tri(i_tri), .i_ray(i_ray), .i_tag(i_tag), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_hit(o_hit), .o_t(o_t), .o_tag(o_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (o_valid && i_ready) res_q.push_back({o_hit, o_t, o_tag});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tri_t unit_tri(input logic [31:0] z);
    tri_t v;
    v = '0;
    v[0][2] = z;
    v[1][0] = Q1; v[1][2] = z;
    v[2][1] = Q1; v[2][2] = z;
    return v;
  endfunction

  function automatic ray_bt mk_ray(input logic [31:0] ex, ey, ez, dx, dy, dz);
    ray_bt r;
    r[0][0] = ex; r[0][1] = ey; r[0][2] = ez;
    r[1][0] = dx; r[1][1] = dy; r[1][2] = dz;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(input tri_t tr, input ray_bt ry, input logic [15:0] tag,
                           input logic last, output int xfer_cyc);
    int k;
    i_tri = tr; i_ray = ry; i_tag = tag; i_last = last; i_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!o_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", o_ready, 1);
    xfer_cyc = cyc;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int n);
    int k;
    k = 0;
    while (res_q.size() < n && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, res_q.size(), n);
    @(posedge clk); #1;
  endtask

  task automatic expect_res(input string tag, input logic hit, input logic [31:0] t,
                            input logic [15:0] id);
    res_t r;
    r = '0;
    if (res_q.size() != 0) r = res_q.pop_front();
    check(tag, r, {hit, t, id});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ray_bt ray_std;
    int    t0, t1, k;
    ray_std = mk_ray(Q4, Q4, M1, 0, 0, Q1);
    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_last = 1'b0;
    i_tri = '0; i_ray = '0; i_tag = '0;
    repeat (3) @(posedge clk);
    #1 i_rstn = 1'b1;
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_hit",   o_hit,   0);
    check("rst_t",     o_t,     MAXP);
    check("rst_tag",   o_tag,   0);
    check("rst_ready", o_ready, 1);
    @(posedge clk); #1;

    // Single triangle ray, with latency measurement.
    send_beat(unit_tri(0), ray_std, 16'd5, 1'b1, t0);
    k = 0;
    @(negedge clk);
    while (!o_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    t1 = cyc;
    check("latency", t1 - t0, 4);
    wait_res("single_cnt", 1);
    expect_res("single", 1'b1, Q1, 16'd5);

    // Three triangles, nearest in the middle.
    send_beat(unit_tri(Q3), ray_std, 16'd7, 1'b0, t0);
    send_beat(unit_tri(Q1), ray_std, 16'd6, 1'b0, t0);
    send_beat(unit_tri(Q2), ray_std, 16'd8, 1'b1, t0);
    wait_res("near_cnt", 1);
    expect_res("nearest", 1'b1, Q2, 16'd6);

    // Back-to-back single-triangle rays: misses and boundary hits.
    send_beat(unit_tri(0), mk_ray(Q4, Q4, 0, Q1, 0, 0),   16'd9,  1'b1, t0);
    send_beat(unit_tri(0), mk_ray(Q34, Q34, M1, 0, 0, Q1), 16'd10, 1'b1, t0);
    send_beat(unit_tri(0), mk_ray(Q4, Q4, Q1, 0, 0, Q1),   16'd11, 1'b1, t0);
    send_beat(unit_tri(0), mk_ray(QH, QH, M1, 0, 0, Q1),   16'd12, 1'b1, t0);
    send_beat(unit_tri(0), mk_ray(Q4, Q4, 0, 0, 0, Q1),    16'd13, 1'b1, t0);
    wait_res("edge_cnt", 5);
    expect_res("den_zero",   1'b0, MAXP, 16'd0);
    expect_res("beyond_ab",  1'b0, MAXP, 16'd0);
    expect_res("t_neg",      1'b0, MAXP, 16'd0);
    expect_res("ab_eq_one",  1'b1, Q1,   16'd12);
    expect_res("t_eq_min",   1'b1, 0,    16'd13);

    // Tie keeps the earlier tag; beats separated by idle cycles.
    send_beat(unit_tri(0), ray_std, 16'd3, 1'b0, t0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(unit_tri(0), ray_std, 16'd4, 1'b1, t0);
    // Hit followed by a miss behind the origin.
    send_beat(unit_tri(0),  ray_std, 16'd14, 1'b0, t0);
    send_beat(unit_tri(M2), ray_std, 16'd15, 1'b1, t0);
    wait_res("tie_cnt", 2);
    expect_res("tie",      1'b1, Q1, 16'd3);
    expect_res("hit_miss", 1'b1, Q1, 16'd14);

    // Backpressure: two rays queued behind a held result.
    i_ready = 1'b0;
    send_beat(unit_tri(0),  ray_std, 16'd20, 1'b1, t0);
    send_beat(unit_tri(Q1), ray_std, 16'd21, 1'b1, t0);
    k = 0;
    while (!o_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {o_valid, o_ready, o_hit, o_t, o_tag}, {1'b1, 1'b0, 1'b1, Q1, 16'd20});
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    wait_res("bp_cnt", 2);
    expect_res("bp_first",  1'b1, Q1, 16'd20);
    expect_res("bp_second", 1'b1, Q2, 16'd21);
    repeat (10) @(posedge clk);
    #1;
    check("bp_nodup", res_q.size(), 0);

    // Reset in the middle of a ray discards it.
    send_beat(unit_tri(MH), ray_std, 16'd30, 1'b0, t0);
    send_beat(unit_tri(MH), ray_std, 16'd31, 1'b0, t0);
    repeat (6) @(posedge clk);
    #1 i_rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_none", res_q.size(), 0);
    send_beat(unit_tri(0), ray_std, 16'd5, 1'b1, t0);
    wait_res("rst_mid_cnt", 1);
    expect_res("after_rst", 1'b1, Q1, 16'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
